// File: rtl/pass_guard.sv
// pass_guard -- password-result handler for the door lock.
//
// Consumes the comparator's `right` / `error` levels, turns their rising
// edges into single events, and runs a three-state controller:
//   IDLE    : counts consecutive wrong attempts
//   OPEN    : door unlocked for UNLOCK_CYCLES after the latest correct entry
//   LOCKOUT : attempts ignored for LOCK_CYCLES << level, buzzer at the start
//
// Ports
//   clk      in  : system clock, rising edge
//   rst      in  : synchronous, active-high reset
//   right    in  : comparator "password correct" level
//   error    in  : comparator "password wrong" level
//   unlock   out : door open (registered)
//   lock     out : lockout active (registered)
//   beef     out : buzzer, first min(BEEP_CYCLES, lockout length) cycles of a lockout
//   fail_cnt out : consecutive wrong attempts so far
//   level    out : escalation level, selects the lockout length
//
// Input event semantics: an event is a 0->1 transition of `right` or `error`
// seen between two consecutive clock edges. A level held high is one event.
// If both rise together, the event is an error. The FSM state register is
// named `state` so checkers can bind to it directly.

module pass_guard #(
    parameter int MAX_TRIES     = 3,
    parameter int UNLOCK_CYCLES = 500,
    parameter int LOCK_CYCLES   = 1000,
    parameter int BEEP_CYCLES   = 200,
    parameter int ESCALATE      = 1,
    parameter int MAX_SHIFT     = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             right,
    input  logic                             error,
    output logic                             unlock,
    output logic                             lock,
    output logic                             beef,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic [$clog2(MAX_SHIFT+1)-1:0]   level
);

    localparam int FW       = $clog2(MAX_TRIES + 1);
    localparam int LW       = $clog2(MAX_SHIFT + 1);
    localparam int LOCK_MAX = LOCK_CYCLES << MAX_SHIFT;
    localparam int SPAN     = (LOCK_MAX > UNLOCK_CYCLES) ? LOCK_MAX : UNLOCK_CYCLES;
    localparam int TW       = $clog2(SPAN + 1);
    // Beep counter only has to hold BEEP_CYCLES-1.
    localparam int BW       = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OPEN    = 2'd1;
    localparam logic [1:0] S_LOCKOUT = 2'd2;

    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_BASE   = TW'(LOCK_CYCLES);
    localparam logic [FW-1:0] FAIL_LAST   = FW'(MAX_TRIES - 1);
    localparam logic [LW-1:0] LEVEL_TOP   = LW'(MAX_SHIFT);
    localparam logic [BW-1:0] BEEP_LOAD   = BW'(BEEP_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [TW-1:0] lock_len;
    logic [FW-1:0] fail_n;
    logic [LW-1:0] level_n;
    logic [BW-1:0] beep_cnt;
    logic          right_q;
    logic          error_q;
    logic          err_ev;
    logic          rgt_ev;

    always_comb begin
        err_ev   = error & ~error_q;
        // A simultaneous rise of both inputs is classified as an error only.
        rgt_ev   = right & ~right_q & ~err_ev;
        lock_len = LOCK_BASE << level;

        state_n  = state;
        // Plain countdown that saturates at zero rather than wrapping.
        timer_n  = (timer != '0) ? timer - 1'b1 : '0;
        fail_n   = fail_cnt;
        level_n  = level;

        case (state)
            S_IDLE: begin
                if (rgt_ev) begin
                    fail_n  = '0;
                    level_n = '0;
                    state_n = S_OPEN;
                    timer_n = UNLOCK_LOAD;
                end else if (err_ev) begin
                    if (fail_cnt == FAIL_LAST) begin
                        fail_n  = '0;
                        state_n = S_LOCKOUT;
                        timer_n = lock_len - 1'b1;
                    end else begin
                        fail_n = fail_cnt + 1'b1;
                    end
                end
            end
            S_OPEN: begin
                // A fresh correct entry restarts the open window, even on
                // the edge that would otherwise have closed the door.
                if (rgt_ev) begin
                    timer_n = UNLOCK_LOAD;
                end else if (timer == '0) begin
                    state_n = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_n = S_IDLE;
                    if ((ESCALATE != 0) && (level < LEVEL_TOP)) begin
                        level_n = level + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            fail_cnt <= '0;
            level    <= '0;
            // Reset to 1 so a level held through reset release is not an event.
            right_q  <= 1'b1;
            error_q  <= 1'b1;
            unlock   <= 1'b0;
            lock     <= 1'b0;
            beef     <= 1'b0;
            beep_cnt <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            fail_cnt <= fail_n;
            level    <= level_n;
            right_q  <= right;
            error_q  <= error;
            unlock   <= (state_n == S_OPEN);
            lock     <= (state_n == S_LOCKOUT);

            // Buzzer: on at lockout entry, off after BEEP_CYCLES cycles or
            // when the lockout ends, whichever comes first.
            if ((state != S_LOCKOUT) && (state_n == S_LOCKOUT)) begin
                beef     <= 1'b1;
                beep_cnt <= BEEP_LOAD;
            end else if (state_n == S_LOCKOUT) begin
                if (beep_cnt == '0) begin
                    beef <= 1'b0;
                end else begin
                    beep_cnt <= beep_cnt - 1'b1;
                end
            end else begin
                beef <= 1'b0;
            end
        end
    end

endmodule
